updown_mod_counter: RTL and testbench
=====================================

# updown_mod_counter

Parametrised up/down modulo counter with prescaler, synchronous load, wrap-or-saturate limit handling and a terminal-count strobe. It generalises the board-level 24-bit enable/reset counter to any width and modulus. It keeps the MSB-driven active-low LED output so it can drop straight onto the Cyclone IV board as a visible divider or event counter.

## Interface
Parameters:
- WIDTH, 24, counter width in bits (2..32)
- MODULUS, 2**WIDTH, count range 0..MODULUS-1; 2 ≤ MODULUS ≤ 2**WIDTH
- PRESCALE, 1, enabled clock cycles per count step (1..65536)
- SATURATE, 0, 0 = wrap at limits, 1 = hold at limits

Ports:
- C  input  1  clock, rising edge
- R  input  1  reset, synchronous, active-high
- T  input  1  count enable, active-high
- U  input  1  direction: 1 = up, 0 = down
- L  input  1  synchronous load strobe, active-high
- D  input  WIDTH  load value
- Q  output  WIDTH  count value, registered
- TC  output  1  terminal-count strobe, registered, one cycle per limit step
- LedQ  output  1  = !Q[WIDTH-1], for the active-low board LED

## Operation
- Internal prescaler P, width clog2(PRESCALE) (1 bit minimum). When PRESCALE = 1, P is a constant 0.
- Step strobe S = T & (P == PRESCALE-1). When T=1 and S=0, P increments. When S=1, P returns to 0. When T=0, P and Q hold.
- Priority, evaluated per edge: R > L > S > hold.
- R: Q=0, P=0, TC=0 (synchronizer flops also 0 when the macro is defined).
- L: Q = D if D < MODULUS, else Q = MODULUS-1. P=0, TC=0. A pending step in the same cycle is discarded.
- S with U=1:
  - Q < MODULUS-1: Q+1.
  - Q = MODULUS-1: Q=0 (SATURATE=0) or hold (SATURATE=1). TC=1 in both cases.
- S with U=0:
  - Q > 0: Q-1.
  - Q = 0: Q=MODULUS-1 (SATURATE=0) or hold (SATURATE=1). TC=1 in both cases.
- U is sampled only on the S cycle. Changing U mid-prescale does not reset P.
- TC is 0 on every edge not described above. It never stays high for two consecutive cycles unless consecutive S cycles hit a limit (only possible with PRESCALE=1).
- Arithmetic is done at WIDTH+1 bits internally. The comparison against MODULUS-1 is exact; there is no reliance on natural overflow, even when MODULUS = 2**WIDTH.

## Timing
- Reset values: Q=0, TC=0, LedQ=1, P=0.
- Latency, PRESCALE=1, macro undefined: T=1 sampled at edge n gives the new Q after edge n. TC is valid in the same cycle as the wrapped or held Q.
- Latency with prescaler: the first step occurs PRESCALE enabled edges after the last load, reset or S.
- L and R take effect at the edge where they are sampled. Q shows the new value in the following cycle.
- Reset asserted mid-prescale or mid-count discards all state. Counting restarts from P=0, Q=0 after R deasserts.
- D must be stable at the edge on which the (synchronized) L is sampled.

## Configuration
- Macro COUNTER_INPUT_SYNC_EN.
- Defined: T, U and L each pass through a 2-flop synchronizer clocked by C and reset by R. The synchronizers allow direct button/switch drive. Effective latency of T, U and L is +2 cycles. D is not synchronized. R is not synchronized.
- Undefined: T, U and L are used directly. Inputs must already be synchronous to C.

## Test plan
- Reset: WIDTH=4, MODULUS=10, R=1 for 2 cycles with T=1 -> Q=0, TC=0, LedQ=1 throughout. Release R -> Q counts 1,2,… on the following edges.
- Wrap up: MODULUS=10, PRESCALE=1, U=1, T=1 from Q=0 -> Q reaches 9, then 0. TC=1 only in the cycle Q=0 after the wrap. Exactly one TC per 10 cycles.
- Down/saturate: SATURATE=1, U=0, load D=2, T=1 -> Q goes 2,1,0,0,0. TC=1 on each step attempted at 0 (every cycle once at 0).
- Prescaler: PRESCALE=4, T=1 for 12 cycles, then T=0 for 5 cycles, then T=1 -> Q increments every 4th enabled cycle (Q=3 after 12 cycles). Q and P are frozen during T=0. The next step comes 4 enabled cycles after re-enable.
- Load priority and clamp: MODULUS=10, L=1 and S=1 in the same cycle with D=15 -> Q=9, TC=0, P=0. R=1 together with L=1 -> Q=0.
- Macro build: COUNTER_INPUT_SYNC_EN defined, single-cycle T pulse at PRESCALE=1 -> Q increments 2 cycles later than in the undefined build. R mid-pipeline clears the pending pulse, and Q stays 0.

Source files
------------

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: parametrised up/down modulo counter.
//   Optional prescaler, synchronous load with clamp to MODULUS-1, wrap or
//   saturate at the limits, and a one-cycle terminal-count strobe.
//   Build option: define COUNTER_INPUT_SYNC_EN to pass T, U and L through
//   2-flop synchronizers, so they can be driven straight from buttons or
//   switches. This adds 2 cycles of latency on those three inputs.
// Ports:
//   C    - clock, rising edge
//   R    - synchronous reset, active-high
//   T    - count enable
//   U    - direction (1 = up, 0 = down)
//   L    - synchronous load strobe
//   D    - load value [WIDTH-1:0]
//   Q    - count value, registered
//   TC   - terminal-count strobe, registered
//   LedQ - registered copy of !Q[WIDTH-1], drives the active-low board LED
module updown_mod_counter #(
    parameter int unsigned     WIDTH    = 24,
    parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
    parameter int unsigned     PRESCALE = 1,
    parameter int unsigned     SATURATE = 0
) (
    input  logic             C,
    input  logic             R,
    input  logic             T,
    input  logic             U,
    input  logic             L,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             LedQ
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
    // Limit kept one bit wider so MODULUS = 2**WIDTH compares exactly
    localparam logic [WIDTH:0] LIMIT_X = (WIDTH+1)'(MODULUS - 64'd1);

    logic tEff, uEff, lEff;

`ifdef COUNTER_INPUT_SYNC_EN
    // Two-flop synchronizers for the asynchronous control inputs
    logic [1:0] tSync, uSync, lSync;

    always_ff @(posedge C) begin
        if (R) begin
            tSync <= '0;
            uSync <= '0;
            lSync <= '0;
        end else begin
            tSync <= {tSync[0], T};
            uSync <= {uSync[0], U};
            lSync <= {lSync[0], L};
        end
    end

    assign tEff = tSync[1];
    assign uEff = uSync[1];
    assign lEff = lSync[1];
`else
    assign tEff = T;
    assign uEff = U;
    assign lEff = L;
`endif

    logic [PW-1:0]    pReg, pNext;
    logic [WIDTH-1:0] qNext;
    logic             tcNext;
    logic [WIDTH:0]   qExt, dExt;
    logic             stepC;

    assign qExt  = {1'b0, Q};
    assign dExt  = {1'b0, D};
    assign stepC = tEff && (pReg == P_LAST);

    // Next-state: load beats step beats prescale/hold
    always_comb begin
        pNext  = pReg;
        qNext  = Q;
        tcNext = 1'b0;
        if (lEff) begin
            pNext = '0;
            qNext = (dExt > LIMIT_X) ? WIDTH'(LIMIT_X) : D;
        end else if (stepC) begin
            pNext = '0;
            if (uEff) begin
                if (qExt == LIMIT_X) begin
                    tcNext = 1'b1;
                    qNext  = (SATURATE != 0) ? Q : '0;
                end else begin
                    qNext = WIDTH'(qExt + 1'b1);
                end
            end else begin
                if (qExt == '0) begin
                    tcNext = 1'b1;
                    qNext  = (SATURATE != 0) ? Q : WIDTH'(LIMIT_X);
                end else begin
                    qNext = WIDTH'(qExt - 1'b1);
                end
            end
        end else if (tEff) begin
            pNext = pReg + 1'b1;
        end
    end

    // State and registered outputs
    always_ff @(posedge C) begin
        if (R) begin
            pReg <= '0;
            Q    <= '0;
            TC   <= 1'b0;
            LedQ <= 1'b1;
        end else begin
            pReg <= pNext;
            Q    <= qNext;
            TC   <= tcNext;
            LedQ <= ~qNext[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench for updown_mod_counter: three 4-bit, modulus-10
// instances (wrap, saturate, prescale-by-4) driven by directed vectors.
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       r [3];
    logic       t [3];
    logic       u [3];
    logic       l [3];
    logic [3:0] d [3];
    logic [3:0] q [3];
    logic       tc [3];
    logic       led [3];

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) dutWrap (
        .C(clk), .R(r[0]), .T(t[0]), .U(u[0]), .L(l[0]), .D(d[0]),
        .Q(q[0]), .TC(tc[0]), .LedQ(led[0]));

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) dutSat (
        .C(clk), .R(r[1]), .T(t[1]), .U(u[1]), .L(l[1]), .D(d[1]),
        .Q(q[1]), .TC(tc[1]), .LedQ(led[1]));

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(4), .SATURATE(0)) dutPre (
        .C(clk), .R(r[2]), .T(t[2]), .U(u[2]), .L(l[2]), .D(d[2]),
        .Q(q[2]), .TC(tc[2]), .LedQ(led[2]));

    // Scoreboard: one expected entry per issued vector
    int         sbId [$];
    logic [3:0] sbQ  [$];
    logic       sbTc [$];
    string      sbNm [$];

    int total = 0;
    int bad   = 0;

    // Issue one vector at the falling edge; its result is checked after the next rising edge
    task automatic vec(input int id, input logic rr, input logic tt, input logic uu,
                       input logic ll, input logic [3:0] dd,
                       input logic [3:0] eq, input logic etc, input string nm);
        @(negedge clk);
        r[id] = rr; t[id] = tt; u[id] = uu; l[id] = ll; d[id] = dd;
        sbId.push_back(id);
        sbQ.push_back(eq);
        sbTc.push_back(etc);
        sbNm.push_back(nm);
    endtask

    // Monitor: compare outputs against the oldest expectation
    always @(posedge clk) begin
        int         id;
        logic [3:0] eq;
        logic       etc;
        string      nm;
        #1;
        if (sbId.size() > 0) begin
            id  = sbId.pop_front();
            eq  = sbQ.pop_front();
            etc = sbTc.pop_front();
            nm  = sbNm.pop_front();
            total += 3;
            if (q[id] !== eq) begin
                bad++;
                $display("FAIL %s Q: got %0d want %0d", nm, q[id], eq);
            end
            if (tc[id] !== etc) begin
                bad++;
                $display("FAIL %s TC: got %0b want %0b", nm, tc[id], etc);
            end
            if (led[id] !== ~eq[3]) begin
                bad++;
                $display("FAIL %s LedQ: got %0b want %0b", nm, led[id], ~eq[3]);
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            r[i] = 1'b1; t[i] = 1'b0; u[i] = 1'b1; l[i] = 1'b0; d[i] = 4'd0;
        end

`ifdef COUNTER_INPUT_SYNC_EN
        // Synchronized inputs: single T pulse lands 2 edges later
        vec(0, 1, 0, 1, 0, 0, 0, 0, "sync_rst");
        vec(0, 0, 0, 1, 0, 0, 0, 0, "sync_idle");
        vec(0, 0, 1, 1, 0, 0, 0, 0, "sync_pulse_e0");
        vec(0, 0, 0, 1, 0, 0, 0, 0, "sync_pulse_e1");
        vec(0, 0, 0, 1, 0, 0, 1, 0, "sync_pulse_e2");
        vec(0, 0, 0, 1, 0, 0, 1, 0, "sync_pulse_e3");
        // Reset mid-pipeline discards the pending pulse
        vec(0, 0, 1, 1, 0, 0, 1, 0, "sync_pend");
        vec(0, 1, 0, 1, 0, 0, 0, 0, "sync_rst_mid");
        vec(0, 0, 0, 1, 0, 0, 0, 0, "sync_after_rst0");
        vec(0, 0, 0, 1, 0, 0, 0, 0, "sync_after_rst1");
        vec(0, 0, 0, 1, 0, 0, 0, 0, "sync_after_rst2");
`else
        // Reset held with T=1, then count up through two wraps
        vec(0, 1, 1, 1, 0, 0, 0, 0, "rst_hold0");
        vec(0, 1, 1, 1, 0, 0, 0, 0, "rst_hold1");
        for (int i = 1; i <= 20; i++)
            vec(0, 0, 1, 1, 0, 0, 4'(i % 10), (i % 10) == 0, "wrap_up");
        // Down from 0 wraps to 9 with TC
        vec(0, 0, 1, 0, 0, 0, 9, 1, "wrap_down");
        vec(0, 0, 1, 0, 0, 0, 8, 0, "down_step");
        // Load beats step, D=15 clamps to 9
        vec(0, 0, 1, 1, 1, 15, 9, 0, "load_clamp");
        vec(0, 0, 1, 1, 0, 0, 0, 1, "wrap_after_load");
        // Reset beats load
        vec(0, 1, 1, 1, 1, 5, 0, 0, "rst_over_load");
        vec(0, 0, 0, 1, 1, 7, 7, 0, "load_no_t");
        vec(0, 0, 0, 1, 0, 0, 7, 0, "hold_t0");
        vec(0, 0, 0, 1, 0, 0, 7, 0, "hold_t0b");

        // Saturating instance: load 2, count down and stick at 0
        vec(1, 0, 0, 0, 0, 0, 0, 0, "sat_idle");
        vec(1, 0, 1, 0, 1, 2, 2, 0, "sat_load2");
        vec(1, 0, 1, 0, 0, 0, 1, 0, "sat_dn1");
        vec(1, 0, 1, 0, 0, 0, 0, 0, "sat_dn0");
        vec(1, 0, 1, 0, 0, 0, 0, 1, "sat_hold0a");
        vec(1, 0, 1, 0, 0, 0, 0, 1, "sat_hold0b");
        vec(1, 0, 1, 1, 0, 0, 1, 0, "sat_up1");
        vec(1, 0, 1, 1, 1, 8, 8, 0, "sat_load8");
        vec(1, 0, 1, 1, 0, 0, 9, 0, "sat_up9");
        vec(1, 0, 1, 1, 0, 0, 9, 1, "sat_hold9a");
        vec(1, 0, 1, 1, 0, 0, 9, 1, "sat_hold9b");
        vec(1, 0, 1, 0, 0, 0, 8, 0, "sat_dn8");

        // Prescale by 4: step every 4th enabled edge
        vec(2, 0, 0, 1, 0, 0, 0, 0, "pre_idle");
        for (int k = 1; k <= 12; k++)
            vec(2, 0, 1, 1, 0, 0, 4'(k / 4), 0, "pre_run");
        for (int k = 0; k < 5; k++)
            vec(2, 0, 0, 1, 0, 0, 3, 0, "pre_frozen");
        vec(2, 0, 1, 1, 0, 0, 3, 0, "pre_re1");
        vec(2, 0, 1, 1, 0, 0, 3, 0, "pre_re2");
        vec(2, 0, 1, 1, 0, 0, 3, 0, "pre_re3");
        vec(2, 0, 1, 1, 0, 0, 4, 0, "pre_re4");
        // Direction only matters on the step edge
        vec(2, 0, 1, 1, 0, 0, 4, 0, "pre_dir1");
        vec(2, 0, 1, 1, 0, 0, 4, 0, "pre_dir2");
        vec(2, 0, 1, 0, 0, 0, 4, 0, "pre_dir3");
        vec(2, 0, 1, 0, 0, 0, 3, 0, "pre_dir4");
        // Load mid-prescale restarts the prescaler
        vec(2, 0, 1, 0, 0, 0, 3, 0, "pre_ld_a");
        vec(2, 0, 1, 0, 0, 0, 3, 0, "pre_ld_b");
        vec(2, 0, 1, 0, 1, 6, 6, 0, "pre_ld");
        vec(2, 0, 1, 0, 0, 0, 6, 0, "pre_ld1");
        vec(2, 0, 1, 0, 0, 0, 6, 0, "pre_ld2");
        vec(2, 0, 1, 0, 0, 0, 6, 0, "pre_ld3");
        vec(2, 0, 1, 0, 0, 0, 5, 0, "pre_ld4");
        // Reset mid-prescale clears P as well as Q
        vec(2, 0, 1, 1, 0, 0, 5, 0, "pre_rs_a");
        vec(2, 0, 1, 1, 0, 0, 5, 0, "pre_rs_b");
        vec(2, 1, 1, 1, 0, 0, 0, 0, "pre_rst");
        vec(2, 0, 1, 1, 0, 0, 0, 0, "pre_rs1");
        vec(2, 0, 1, 1, 0, 0, 0, 0, "pre_rs2");
        vec(2, 0, 1, 1, 0, 0, 0, 0, "pre_rs3");
        vec(2, 0, 1, 1, 0, 0, 1, 0, "pre_rs4");
`endif

        // Drain the scoreboard with a bounded wait
        for (int c = 0; c < 10 && sbId.size() > 0; c++)
            @(posedge clk);
        #2;
        if (sbId.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending %0d want 0", sbId.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
